// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  alu_pkg -- opcode encodings and FSM state type shared by the alu_seq block
//  Revision: 1.0
// ============================================================================
package alu_pkg;

  localparam logic [2:0] OP_XOR  = 3'b000;
  localparam logic [2:0] OP_SLTU = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
//  alu_mul_iter -- iterative shift-add multiplier, fixed WIDTH-cycle latency
//  Revision: 1.0
// ============================================================================
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_p
);

  localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_acc_next;

  always_comb begin
    w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (r_cnt == C_LAST) begin
        r_busy <= 1'b0;
      end
    end
  end

  // The final partial product is folded in combinationally so the owner can
  // register the full product on the same edge as the last step.
  assign o_done = r_busy && (r_cnt == C_LAST);
  assign o_p    = w_acc_next;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  alu_seq -- handshaked ALU with registered result/flags and iterative MUL
//  Revision: 1.0
// ============================================================================
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
);

  import alu_pkg::*;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_ovf;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_mul_start;
  logic             w_load_alu;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_p;

  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu_y;
  logic             w_alu_c;
  logic             w_alu_v;
  logic [WIDTH-1:0] w_res_y;
  logic             w_res_c;
  logic             w_res_v;

  assign w_accept    = in_valid && w_in_ready;
  assign w_mul_start = w_accept && (f == OP_MUL) && MUL_EN;
  assign w_load_alu  = w_accept && !w_mul_start;

  // Single adder serves ADD and SUB: SUB is a + ~b + 1.
  always_comb begin
    w_is_sub = (f == OP_SUB);
    w_b_eff  = w_is_sub ? ~b : b;
    w_sum    = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
  end

  always_comb begin
    w_alu_y = '0;
    w_alu_c = 1'b0;
    w_alu_v = 1'b0;
    case (f)
      OP_ADD, OP_SUB: begin
        w_alu_y = w_sum[WIDTH-1:0];
        w_alu_c = w_sum[WIDTH];
        w_alu_v = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_alu_y = a & b;
      OP_OR:   w_alu_y = a | b;
      OP_XOR:  w_alu_y = a ^ b;
      OP_SLT:  w_alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
      default: w_alu_y = '0;
    endcase
  end

  always_comb begin
    w_res_y = w_mul_done ? w_mul_p : w_alu_y;
    w_res_c = w_mul_done ? 1'b0 : w_alu_c;
    w_res_v = w_mul_done ? 1'b0 : w_alu_v;
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_iter #(
        .WIDTH (WIDTH)
      ) u_mul (
        .clk     (clk),
        .rst     (reset),
        .i_start (w_mul_start),
        .i_a     (a),
        .i_b     (b),
        .o_done  (w_mul_done),
        .o_p     (w_mul_p)
      );
    end else begin : g_no_mul
      assign w_mul_done = 1'b0;
      assign w_mul_p    = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_mul_start) w_state_next = ST_MUL;
      ST_MUL:  if (w_mul_done)  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  end

  // A new result overrides the consume-clear so back-to-back ops see no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_load_alu || w_mul_done) begin
      r_out_valid <= 1'b1;
      r_y         <= w_res_y;
      r_zero      <= (w_res_y == '0);
      r_neg       <= w_res_y[WIDTH-1];
      r_carry     <= w_res_c;
      r_ovf       <= w_res_v;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign carry     = r_carry;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  tb_alu_seq -- directed vectors for alu_seq (32-bit with MUL, 8-bit without)
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_alu_seq;

  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        iv32, ir32, ov32, or32, z32, n32, c32, o32;
  logic [31:0] a32, b32, y32;
  logic [2:0]  f32;
  logic        iv8, ir8, ov8, or8, z8, n8, c8, o8;
  logic [7:0]  a8, b8, y8;
  logic [2:0]  f8;

  alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .f(f32), .out_valid(ov32), .out_ready(or32),
    .y(y32), .zero(z32), .neg(n32), .carry(c32), .ovf(o32)
  );

  alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .f(f8), .out_valid(ov8), .out_ready(or8),
    .y(y8), .zero(z8), .neg(n8), .carry(c8), .ovf(o8)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] z);
    case (op)
      OP_AND:  return x & z;
      OP_OR:   return x | z;
      default: return x ^ z;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] expq[$];
    logic [31:0] hold_y;
    logic [2:0]  tog_ops[3];
    int          n, bad, acc_cnt, cons_cnt, cyc;
    logic        hold_pending;

    vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{OP_SUB,  32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{OP_SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_OR,   32'h80000000, 32'h00000001, 32'h80000001, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{OP_XOR,  32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{OP_SLT,  32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{OP_SLT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{OP_SLT,  32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
    tog_ops[0] = OP_AND;
    tog_ops[1] = OP_OR;
    tog_ops[2] = OP_XOR;

    reset = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; f32 = OP_ADD; or32 = 1'b1;
    iv8  = 1'b0; a8  = '0; b8  = '0; f8  = OP_ADD; or8  = 1'b1;
    tick; tick;
    reset = 1'b0;
    check("reset32", {ov32, y32, z32, n32, c32, o32, ir32}, {1'b0, 32'h0, 4'h0, 1'b1});
    check("reset8",  {ov8,  y8,  z8,  n8,  c8,  o8,  ir8},  {1'b0, 8'h0,  4'h0, 1'b1});

    // Single-cycle vectors, each result consumed by the next accept.
    for (int i = 0; i < NV; i++) begin
      a32 = vecs[i].a; b32 = vecs[i].b; f32 = vecs[i].f; iv32 = 1'b1;
      tick;
      iv32 = 1'b0;
      check($sformatf("vec%0d", i), {ov32, y32, z32, n32, c32, o32},
            {1'b1, vecs[i].y, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v});
    end
    tick;

    // MUL latency, busy stall and output hold under backpressure.
    a32 = 32'd7; b32 = 32'hFFFFFFFD; f32 = OP_MUL; iv32 = 1'b1; or32 = 1'b0;
    tick;
    iv32 = 1'b0;
    n = 0; bad = 0;
    while (!ov32 && n < 100) begin
      if (ir32) bad = 1;
      tick;
      n++;
    end
    check("mul_latency", n, 32);
    check("mul_ready_low", bad, 0);
    check("mul_y", {ov32, y32, z32, n32, c32, o32}, {1'b1, 32'hFFFFFFEB, 4'b0100});
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (!ov32 || y32 !== 32'hFFFFFFEB || !n32 || ir32) bad = 1;
    end
    check("mul_hold", bad, 0);
    or32 = 1'b1;
    tick;
    check("mul_consumed", {ov32, ir32}, 2'b01);

    // Back-to-back single-cycle ops, one result per cycle.
    iv32 = 1'b1;
    a32 = 32'hFF00FF00; b32 = 32'h0F0F0F0F; f32 = OP_AND; tick;
    check("b2b_and", {ov32, ir32, y32}, {2'b11, 32'h0F000F00});
    f32 = OP_OR; tick;
    check("b2b_or",  {ov32, ir32, y32}, {2'b11, 32'hFF0FFF0F});
    f32 = OP_XOR; tick;
    check("b2b_xor", {ov32, ir32, y32}, {2'b11, 32'hF00FF00F});
    a32 = 32'h12345678; b32 = 32'hFFFF0000; f32 = OP_AND; tick;
    check("b2b_and2", {ov32, ir32, y32}, {2'b11, 32'h12340000});
    iv32 = 1'b0;
    tick;
    check("b2b_drain", ov32, 1'b0);

    // out_ready toggling: scoreboard for loss, duplication and hold.
    acc_cnt = 0; cons_cnt = 0; cyc = 0; bad = 0; hold_pending = 1'b0; hold_y = '0;
    while ((acc_cnt < 6 || expq.size() != 0) && cyc < 60) begin
      if (hold_pending && (!ov32 || y32 !== hold_y)) bad++;
      or32 = (cyc % 2) == 0;
      iv32 = acc_cnt < 6;
      a32  = 32'hA5A50000 + acc_cnt;
      b32  = 32'h0F0FF0F0;
      f32  = tog_ops[acc_cnt % 3];
      #1;
      if (ov32 && or32) begin
        if (expq.size() == 0) bad++;
        else if (y32 !== expq.pop_front()) bad++;
        cons_cnt++;
      end
      hold_pending = ov32 && !or32;
      hold_y = y32;
      if (iv32 && ir32) begin
        expq.push_back(model(f32, a32, b32));
        acc_cnt++;
      end
      tick;
      cyc++;
    end
    iv32 = 1'b0;
    check("tog_count", cons_cnt, 6);
    check("tog_order", bad, 0);
    check("tog_drain", ov32, 1'b0);

    // Reset in the middle of a MUL.
    or32 = 1'b1; a32 = 32'd5; b32 = 32'd9; f32 = OP_MUL; iv32 = 1'b1;
    tick;
    iv32 = 1'b0;
    repeat (10) tick;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    check("rst_mid_mul", {ov32, y32, z32, n32, c32, o32, ir32}, {1'b0, 32'h0, 4'h0, 1'b1});
    bad = 0;
    repeat (40) begin
      tick;
      if (ov32) bad = 1;
    end
    check("rst_no_stale", bad, 0);

    // WIDTH=8 without multiplier.
    a8 = 8'hFF; b8 = 8'h01; f8 = OP_ADD; iv8 = 1'b1;
    tick;
    iv8 = 1'b0;
    check("w8_add", {ov8, y8, z8, n8, c8, o8}, {1'b1, 8'h00, 4'b1010});
    a8 = 8'h07; b8 = 8'h03; f8 = OP_MUL; iv8 = 1'b1;
    tick;
    iv8 = 1'b0;
    check("w8_mul", {ov8, y8, z8, ir8}, {1'b1, 8'h00, 1'b1, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the lab single-cycle ALU; sits between the register-file read stage and writeback.
- Same 3-bit opcode encoding as the existing ALU, plus XOR, unsigned SLT and an iterative multiply.
- Valid/ready on input and output; registered result with full flag set (zero, negative, carry, overflow).
- Backpressure is honoured: a result is held until it is consumed.

Parameters:
- WIDTH, 32: operand/result width in bits (≥4).
- MUL_EN, 1: 1 = MUL opcode implemented; 0 = MUL returns zero in one cycle.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A, signed
- b  in  WIDTH  operand B, signed
- f  in  3  opcode
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result this cycle
- y  out  WIDTH  result
- zero  out  1  y == 0
- neg  out  1  y[WIDTH-1]
- carry  out  1  carry-out (ADD/SUB only)
- ovf  out  1  signed overflow (ADD/SUB only)

Behaviour:
- Opcodes:
  - 010 ADD
  - 110 SUB
  - 011 AND
  - 100 OR
  - 000 XOR
  - 111 SLT signed: y = 1 if $signed(a) < $signed(b), else 0; true comparison, correct under subtraction overflow.
  - 001 SLTU unsigned.
  - 101 MUL: low WIDTH bits of a*b.
- Accept: in_valid && in_ready at a rising edge (E0). Operands are sampled only at accept.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A new op may be accepted in the same cycle the previous result is consumed.
- Single-cycle ops: result and flags are registered at E0; out_valid = 1 after E0 (1-edge latency).
- MUL (MUL_EN=1):
  - E0 loads the multiplicand, multiplier and a counter; the state goes to MUL.
  - One shift-add step per edge, E1..E_WIDTH.
  - The result is registered at E_WIDTH; out_valid = 1 after E_WIDTH.
  - in_ready = 0 throughout MUL.
- MUL_EN=0: MUL behaves as a single-cycle op with y = 0.
- FSM states:
  - IDLE: accept -> MUL if f==101 && MUL_EN, else stay IDLE with the result loaded.
  - MUL: counter==WIDTH-1 at an edge -> IDLE with the result loaded.
- Output hold: while out_valid && !out_ready, y and all flags are stable and no op is accepted.
- out_valid clears at the consuming edge unless a new single-cycle op is accepted at that same edge, in which case it stays 1 with the new result.
- Flags:
  - zero and neg are computed from the final y for every op.
  - carry: ADD = carry-out of a+b; SUB = carry-out of a+~b+1 (1 means no borrow, i.e. a ≥ b unsigned).
  - ovf: ADD/SUB signed overflow. carry = ovf = 0 for all other ops.
- Arithmetic is modulo 2^WIDTH; carry uses a WIDTH+1-bit internal sum.
- Reset (any state, including mid-MUL):
  - The in-flight op is aborted; state = IDLE, counter = 0.
  - out_valid = 0, y = 0, zero = neg = carry = ovf = 0.
  - in_ready = 1 on the first cycle after reset deasserts.
- Flags are meaningful only while out_valid = 1.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_MUL;
  - FSM state typedef (IDLE, MUL).
- Sub-module alu_mul_iter (WIDTH):
  - start/done iterative shift-add multiplier with a WIDTH-cycle fixed latency and the same synchronous reset;
  - instantiated only under MUL_EN.
- The remainder of alu_seq is the op decode/flag logic, the FSM and the output register.

Test Plan:
- Reset-then-idle: hold reset 2 cycles mid-MUL -> out_valid=0, y=0, all flags 0, in_ready=1 the cycle after release; no stale result appears.
- ADD overflow, WIDTH=32: a=0x7FFFFFFF, b=1, f=010 -> next cycle y=0x80000000, ovf=1, neg=1, carry=0, zero=0.
- SUB equality and SLT under overflow:
  - SUB with a=b=0x1234 (f=110) -> y=0, zero=1, carry=1.
  - SLT with a=0x80000000, b=1 (f=111) -> y=1.
  - SLTU with the same operands (f=001) -> y=0.
- MUL latency and stall: a=7, b=0xFFFFFFFD, f=101 -> in_ready=0 for 32 cycles; out_valid rises after edge E32 with y=0xFFFFFFEB; with out_ready=0, y is held 5 cycles, then consumed.
- Back-to-back throughput: out_ready=1, in_valid=1 with 4 consecutive AND/OR/XOR ops -> one result per cycle, in order, no bubbles; with out_ready toggling 1/0, each result is held until consumed and none is lost or duplicated.
- Parameter sweep: WIDTH=8, MUL_EN=0:
  - ADD 0xFF+0x01 -> y=0x00, carry=1, zero=1.
  - MUL -> y=0 after 1 edge.
